// File: rtl/mcp300x_scan.sv
// MCP300x multi-channel scan controller: sweeps the enabled channels over
// the ADC serial link, one frame per channel, and queues {channel, sample}
// results in a first-word fall-through FIFO.
module mcp300x_scan #(
  parameter int unsigned CLK_FREQ      = 27_000_000,
  parameter int unsigned SCLK_FREQ     = 900_000,
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned RES_BITS      = 10,
  parameter int unsigned SAMPLE_PERIOD = 5400,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CS_GAP        = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  input  logic                sgl_diff,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic                flag_clr,
  output logic                busy,
  output logic                adc_cs,
  output logic                adc_clk,
  output logic                adc_din,
  input  logic                adc_dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RES_BITS-1:0] out_data,
  output logic [2:0]          out_ch,
  output logic                overrun,
  output logic                missed
);

  localparam int unsigned HALF    = CLK_FREQ / (2 * SCLK_FREQ);
  localparam int unsigned GAP_LEN = CS_GAP * HALF;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned EW      = RES_BITS + 3;

  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_LEN - 1);
  localparam logic [5:0]  LAST_EDGE = 6'(7 + RES_BITS);
  localparam logic [5:0]  FIRST_SMP = 6'd8;
  localparam logic [31:0] TMR_LAST  = 32'(SAMPLE_PERIOD - 1);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         half_q, half_d;
  logic [5:0]          tog_q, tog_d;
  logic [15:0]         gap_q, gap_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [2:0]          ch_q, ch_d;
  logic                sgl_q, sgl_d;
  logic [RES_BITS-1:0] samp_q, samp_d;
  logic                cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                din_q, din_d;
  logic [31:0]         tmr_q, tmr_d;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [EW-1:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                overrun_q, overrun_d;
  logic                missed_q, missed_d;

  logic              tick;
  logic              launch;
  logic [NUM_CH-1:0] launch_mask;
  logic              push;
  logic              wr;
  logic              pop;
  logic              full;
  logic              ovr_set;
  logic [5:0]        k;
  logic [5:0]        rise;
  logic [5:0]        fall;

  // Index of the lowest set bit; channels are converted in ascending order.
  function automatic logic [2:0] first_ch(input logic [NUM_CH-1:0] m);
    logic [NUM_CH-1:0] s;
    logic              found;
    s        = m;
    found    = 1'b0;
    first_ch = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && s[0]) begin
        first_ch = 3'(i);
        found    = 1'b1;
      end
      s = s >> 1;
    end
  endfunction

  assign pop  = (cnt_q != '0) && out_ready;
  assign full = (cnt_q == (AW+1)'(FIFO_DEPTH));

  // Sweep timer, frame sequencer, FIFO bookkeeping and sticky flags.
  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    tog_d       = tog_q;
    gap_d       = gap_q;
    pend_d      = pend_q;
    ch_d        = ch_q;
    sgl_d       = sgl_q;
    samp_d      = samp_q;
    cs_d        = cs_q;
    sclk_d      = sclk_q;
    din_d       = din_q;
    tmr_d       = tmr_q;
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    tick        = 1'b0;
    launch      = 1'b0;
    launch_mask = pend_q;
    push        = 1'b0;
    wr          = 1'b0;
    ovr_set     = 1'b0;
    k           = '0;
    rise        = '0;
    fall        = '0;

    if (!continuous) begin
      tmr_d = '0;
    end else if (tmr_q == TMR_LAST) begin
      tmr_d = '0;
      tick  = 1'b1;
    end else begin
      tmr_d = tmr_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        din_d  = 1'b0;
        if ((start || tick) && (ch_mask != '0)) begin
          launch      = 1'b1;
          launch_mask = ch_mask;
          sgl_d       = sgl_diff;
        end
      end
      ST_FRAME: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          k      = tog_q + 6'd1;
          tog_d  = k;
          rise   = (k + 6'd1) >> 1;
          fall   = k >> 1;
          if (k[0]) begin
            sclk_d = 1'b1;
            if (rise >= FIRST_SMP && rise <= LAST_EDGE) begin
              samp_d = {samp_q[RES_BITS-2:0], adc_dout};
            end
          end else begin
            sclk_d = 1'b0;
            case (fall)
              6'd1:    din_d = sgl_q;
              6'd2:    din_d = ch_q[2];
              6'd3:    din_d = ch_q[1];
              6'd4:    din_d = ch_q[0];
              default: din_d = 1'b0;
            endcase
            if (fall == LAST_EDGE) begin
              cs_d    = 1'b1;
              push    = 1'b1;
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end
        end else begin
          half_d = half_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (pend_q != '0) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Lowest pending channel is taken and cleared via m & (m-1).
    if (launch) begin
      state_d = ST_FRAME;
      ch_d    = first_ch(launch_mask);
      pend_d  = launch_mask & (launch_mask - ONE);
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      din_d   = 1'b1;
      half_d  = '0;
      tog_d   = '0;
    end

    wr      = push && (!full || pop);
    ovr_set = push && !wr;
    if (wr) begin
      mem_d[wptr_q] = {ch_q, samp_q};
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (wr && !pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!wr && pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end

    overrun_d = (overrun_q && !flag_clr) || ovr_set;
    missed_d  = (missed_q && !flag_clr) || (tick && (state_q != ST_IDLE));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      half_q    <= '0;
      tog_q     <= '0;
      gap_q     <= '0;
      pend_q    <= '0;
      ch_q      <= '0;
      sgl_q     <= 1'b0;
      samp_q    <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      tmr_q     <= '0;
      mem_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      tog_q     <= tog_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
      ch_q      <= ch_d;
      sgl_q     <= sgl_d;
      samp_q    <= samp_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      tmr_q     <= tmr_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      missed_q  <= missed_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign adc_cs    = cs_q;
  assign adc_clk   = sclk_q;
  assign adc_din   = din_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rptr_q][RES_BITS-1:0];
  assign out_ch    = mem_q[rptr_q][EW-1:RES_BITS];
  assign overrun   = overrun_q;
  assign missed    = missed_q;

endmodule
